// File: rtl/fpga_imem_pkg.sv
// Shared types for the imem port-B load controller: checker states and the
// round-robin pointer used when host and checker contend for the port.
package fpga_imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  typedef enum logic {
    PTR_HOST = 1'b0,
    PTR_CHK  = 1'b1
  } rr_ptr_e;

  localparam int CHK_SUM_W = 32;

  // After a contended cycle, favour whoever lost it.
  function automatic rr_ptr_e rr_next(input logic host_won);
    return host_won ? PTR_CHK : PTR_HOST;
  endfunction

endpackage

// File: rtl/imem_chk_engine.sv
// Checksum engine: walks addresses 0..len-1 through the shared port and
// accumulates the returned words modulo 2^32.
module imem_chk_engine
  import fpga_imem_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                 core_clk,
  input  logic                 cptra_rst_b,
  input  logic                 chk_start,
  input  logic [ADDR_W:0]      chk_len,
  input  logic                 chk_gnt,
  input  logic [DATA_W-1:0]    bram_rdata,
  output logic                 chk_req,
  output logic [ADDR_W-1:0]    chk_addr,
  output logic                 chk_busy,
  output logic                 chk_done,
  output logic [CHK_SUM_W-1:0] chk_sum
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  chk_state_e             state_reg, state_next;
  logic [ADDR_W:0]        cnt_reg, cnt_next;
  logic [ADDR_W:0]        len_reg, len_next;
  logic [CHK_SUM_W-1:0]   sum_reg, sum_next;
  logic                   rd_pend_reg;
  logic [CHK_SUM_W-1:0]   word32;
  logic [ADDR_W:0]        len_clamped;

  if (DATA_W >= CHK_SUM_W) begin : g_trunc
    assign word32 = bram_rdata[CHK_SUM_W-1:0];
  end else begin : g_zext
    assign word32 = {{(CHK_SUM_W-DATA_W){1'b0}}, bram_rdata};
  end

  // The counter is one bit wider than the address so a full-depth run
  // terminates on the compare instead of wrapping.
  assign len_clamped = (chk_len > LEN_MAX) ? LEN_MAX : chk_len;
  assign chk_addr    = cnt_reg[ADDR_W-1:0];
  assign chk_sum     = sum_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    sum_next   = rd_pend_reg ? (sum_reg + word32) : sum_reg;
    chk_req    = 1'b0;
    chk_busy   = 1'b0;
    chk_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (chk_start) begin
          sum_next   = '0;
          cnt_next   = '0;
          len_next   = len_clamped;
          state_next = (chk_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        chk_req  = 1'b1;
        chk_busy = 1'b1;
        if (chk_gnt) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == len_reg - 1'b1) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The last read's data is accumulated on this cycle's edge.
        chk_busy = 1'b1;
        if (rd_pend_reg) state_next = DONE;
      end
      DONE: begin
        chk_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      len_reg     <= '0;
      sum_reg     <= '0;
      rd_pend_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      len_reg     <= len_next;
      sum_reg     <= sum_next;
      rd_pend_reg <= chk_req && chk_gnt;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// imem BRAM port-B controller: arbitrates host accesses against the checksum
// engine, enforces the ROM write lock and returns host read data.
module imem_load_ctrl
  import fpga_imem_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                 core_clk,
  input  logic                 cptra_rst_b,
  input  logic                 host_req,
  input  logic [3:0]           host_we,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 host_err,
  input  logic                 rom_lock,
  input  logic                 chk_start,
  input  logic [ADDR_W:0]      chk_len,
  output logic                 chk_busy,
  output logic                 chk_done,
  output logic [CHK_SUM_W-1:0] chk_sum,
  output logic                 bram_en,
  output logic [3:0]           bram_we,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic [DATA_W-1:0]    bram_wdata,
  input  logic [DATA_W-1:0]    bram_rdata
);

  rr_ptr_e             rr_ptr_reg, rr_ptr_next;
  logic                host_rd_pend_reg;
  logic                host_rvalid_reg;
  logic [DATA_W-1:0]   host_rdata_reg;
  logic                chk_req, chk_win, host_win, locked_wr;
  logic [ADDR_W-1:0]   chk_addr;

  imem_chk_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_chk_engine (
    .core_clk    (core_clk),
    .cptra_rst_b (cptra_rst_b),
    .chk_start   (chk_start),
    .chk_len     (chk_len),
    .chk_gnt     (chk_win),
    .bram_rdata  (bram_rdata),
    .chk_req     (chk_req),
    .chk_addr    (chk_addr),
    .chk_busy    (chk_busy),
    .chk_done    (chk_done),
    .chk_sum     (chk_sum)
  );

  // Grants are combinational, so they are also gated by reset to keep every
  // output low while reset is held.
  always_comb begin
    host_win    = 1'b0;
    chk_win     = 1'b0;
    locked_wr   = 1'b0;
    rr_ptr_next = rr_ptr_reg;
    host_gnt    = 1'b0;
    host_err    = 1'b0;
    bram_en     = 1'b0;
    bram_we     = '0;
    bram_addr   = '0;
    bram_wdata  = '0;
    if (cptra_rst_b) begin
      host_win  = host_req && (!chk_req || rr_ptr_reg == PTR_HOST);
      chk_win   = chk_req && !host_win;
      locked_wr = host_win && rom_lock && (host_we != 4'b0);
      if (host_req && chk_req) rr_ptr_next = rr_next(host_win);
      host_gnt = host_win;
      host_err = locked_wr;
      if (host_win && !locked_wr) begin
        bram_en    = 1'b1;
        bram_we    = host_we;
        bram_addr  = host_addr;
        bram_wdata = host_wdata;
      end else if (chk_win) begin
        bram_en   = 1'b1;
        bram_addr = chk_addr;
      end
    end
  end

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      rr_ptr_reg       <= PTR_HOST;
      host_rd_pend_reg <= 1'b0;
      host_rvalid_reg  <= 1'b0;
      host_rdata_reg   <= '0;
    end else begin
      rr_ptr_reg       <= rr_ptr_next;
      host_rd_pend_reg <= host_win && (host_we == 4'b0);
      host_rvalid_reg  <= host_rd_pend_reg;
      if (host_rd_pend_reg) host_rdata_reg <= bram_rdata;
    end
  end

  assign host_rvalid = host_rvalid_reg;
  assign host_rdata  = host_rdata_reg;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: a behavioural BRAM plus a shadow
// memory model that predicts host read data and checksum results.
module tb_imem_load_ctrl;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              core_clk = 1'b0;
  logic              cptra_rst_b = 1'b0;
  logic              host_req = 1'b0;
  logic [3:0]        host_we = '0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_gnt, host_rvalid, host_err;
  logic [DATA_W-1:0] host_rdata;
  logic              rom_lock = 1'b0;
  logic              chk_start = 1'b0;
  logic [ADDR_W:0]   chk_len = '0;
  logic              chk_busy, chk_done;
  logic [31:0]       chk_sum;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] bram_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];

  imem_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .core_clk(core_clk), .cptra_rst_b(cptra_rst_b),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
    .rom_lock(rom_lock), .chk_start(chk_start), .chk_len(chk_len),
    .chk_busy(chk_busy), .chk_done(chk_done), .chk_sum(chk_sum),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata)
  );

  always #5 core_clk = ~core_clk;

  // Port-B BRAM: read-first, one-cycle registered read.
  always @(posedge core_clk) begin
    if (bram_en) begin
      bram_rdata <= bram_mem[bram_addr];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] = bram_wdata[8*b +: 8];
    end
  end

  function automatic void ref_write(input logic [3:0] we, input int a, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] ref_sum(input int n);
    logic [31:0] s = 0;
    int lim = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < lim; i++) s = s + ref_mem[i];
    return s;
  endfunction

  function automatic void preload(input int a, input logic [31:0] d);
    bram_mem[a] = d;
    ref_mem[a]  = d;
  endfunction

  function automatic logic [118:0] all_outs();
    return {host_gnt, host_rvalid, host_rdata, host_err, chk_busy, chk_done, chk_sum,
            bram_en, bram_we, bram_addr, bram_wdata};
  endfunction

  // Drives one host access, holding the request until granted, and reports
  // what was seen in the grant cycle and the two following cycles.
  task automatic host_op(input logic [3:0] we, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         output int gnt_wait, output logic err_s, output logic en_s,
                         output logic [3:0] we_s, output logic rv1, output logic rv2,
                         output logic [31:0] rd);
    gnt_wait = -1; err_s = 0; en_s = 0; we_s = 0;
    @(negedge core_clk);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (host_gnt) begin
        gnt_wait = n; err_s = host_err; en_s = bram_en; we_s = bram_we;
        break;
      end
      @(negedge core_clk);
    end
    if (gnt_wait >= 0) @(negedge core_clk);
    host_req = 1'b0; host_we = '0;
    #1 rv1 = host_rvalid;
    @(negedge core_clk);
    #1 rv2 = host_rvalid; rd = host_rdata;
  endtask

  task automatic start_chk(input logic [ADDR_W:0] len);
    @(negedge core_clk);
    chk_start = 1'b1; chk_len = len;
    @(negedge core_clk);
    chk_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output logic [31:0] s);
    cyc = -1; s = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge core_clk); #1;
      if (chk_done) begin cyc = n; s = chk_sum; break; end
    end
  endtask

  task automatic test_reset();
    int cyc; logic [31:0] s;
    cptra_rst_b = 1'b0; host_req = 1'b1; host_we = 4'hF; host_addr = 13'h55;
    host_wdata = 32'h1234_5678; chk_start = 1'b1; chk_len = 14'd5;
    repeat (3) @(negedge core_clk);
    #1;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    host_req = 1'b0; host_we = '0; chk_start = 1'b0;
    @(negedge core_clk); cptra_rst_b = 1'b1;
    // First contended cycle after reset must go to the host.
    start_chk(14'd2);
    host_req = 1'b1; host_addr = 13'h0;
    #1;
    vectors++;
    if ({chk_busy, host_gnt} !== 2'b11) begin
      miscompares++; $display("FAIL reset_host_first: busy,gnt=%b expected 11", {chk_busy, host_gnt});
    end
    @(negedge core_clk); host_req = 1'b0;
    wait_done(20, cyc, s);
    vectors++;
    if (cyc < 0 || s !== ref_sum(2)) begin
      miscompares++; $display("FAIL reset_first_sum: got %h (cyc %0d) expected %h", s, cyc, ref_sum(2));
    end
    $display("test_reset: outputs idle under reset, host wins first contention");
  endtask

  task automatic test_write_read();
    int w; logic e, en, r1, r2; logic [3:0] wq; logic [31:0] rd;
    host_op(4'hF, 13'h010, 32'hDEAD_BEEF, w, e, en, wq, r1, r2, rd);
    ref_write(4'hF, 'h010, 32'hDEAD_BEEF);
    vectors++;
    if (w !== 0 || e !== 1'b0 || en !== 1'b1 || wq !== 4'hF) begin
      miscompares++; $display("FAIL wr_grant: wait=%0d err=%b en=%b we=%h expected 0 0 1 f", w, e, en, wq);
    end
    host_op(4'h0, 13'h010, 32'h0, w, e, en, wq, r1, r2, rd);
    vectors++;
    if ({r1, r2} !== 2'b01 || rd !== ref_mem['h010]) begin
      miscompares++; $display("FAIL rd_latency: rv=%b data=%h expected 01 %h", {r1, r2}, rd, ref_mem['h010]);
    end
    @(negedge core_clk); #1;
    vectors++;
    if (host_rvalid !== 1'b0 || host_rdata !== ref_mem['h010]) begin
      miscompares++; $display("FAIL rd_hold: rv=%b data=%h expected 0 %h", host_rvalid, host_rdata, ref_mem['h010]);
    end
    $display("test_write_read: addr=010 data=%h", rd);
  endtask

  task automatic test_checksum_basic();
    int w, cyc; logic e, en, r1, r2; logic [3:0] wq; logic [31:0] rd, s;
    logic [31:0] words [4] = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      host_op(4'hF, ADDR_W'(i), words[i], w, e, en, wq, r1, r2, rd);
      ref_write(4'hF, i, words[i]);
    end
    start_chk(14'd4);
    wait_done(40, cyc, s);
    vectors++;
    if (cyc < 0 || s !== ref_sum(4)) begin
      miscompares++; $display("FAIL chk_basic: got %h (cyc %0d) expected %h", s, cyc, ref_sum(4));
    end
    @(negedge core_clk); #1;
    vectors++;
    if (chk_done !== 1'b0 || chk_busy !== 1'b0 || chk_sum !== ref_sum(4)) begin
      miscompares++; $display("FAIL chk_basic_after: done=%b busy=%b sum=%h expected 0 0 %h",
                              chk_done, chk_busy, chk_sum, ref_sum(4));
    end
    $display("test_checksum_basic: len=4 sum=%h", s);
  endtask

  task automatic test_rom_lock();
    int w; logic e, en, r1, r2; logic [3:0] wq; logic [31:0] rd;
    host_op(4'hF, 13'h020, 32'hA5A5_0001, w, e, en, wq, r1, r2, rd);
    ref_write(4'hF, 'h020, 32'hA5A5_0001);
    rom_lock = 1'b1;
    host_op(4'hF, 13'h020, 32'h5A5A_FFFF, w, e, en, wq, r1, r2, rd);
    vectors++;
    if (w !== 0 || e !== 1'b1 || en !== 1'b0 || wq !== 4'h0) begin
      miscompares++; $display("FAIL lock_write: wait=%0d err=%b en=%b we=%h expected 0 1 0 0", w, e, en, wq);
    end
    host_op(4'h0, 13'h020, 32'h0, w, e, en, wq, r1, r2, rd);
    vectors++;
    if (e !== 1'b0 || r2 !== 1'b1 || rd !== ref_mem['h020]) begin
      miscompares++; $display("FAIL lock_read: err=%b rv=%b data=%h expected 0 1 %h", e, r2, rd, ref_mem['h020]);
    end
    rom_lock = 1'b0;
    $display("test_rom_lock: locked write rejected, read=%h", rd);
  endtask

  task automatic test_len_zero();
    start_chk(14'd0);
    #1;
    vectors++;
    if ({chk_busy, chk_done, chk_sum} !== {1'b0, 1'b1, 32'h0}) begin
      miscompares++; $display("FAIL len_zero: busy=%b done=%b sum=%h expected 0 1 0", chk_busy, chk_done, chk_sum);
    end
    @(negedge core_clk); #1;
    vectors++;
    if (chk_done !== 1'b0) begin
      miscompares++; $display("FAIL len_zero_pulse: done=%b expected 0", chk_done);
    end
    $display("test_len_zero: done one cycle after start, sum=0");
  endtask

  task automatic test_contention();
    int nchk = 0, cyc; logic prev = 0, first = 1; logic [31:0] s;
    logic [ADDR_W-1:0] haddr = ADDR_W'($urandom_range(100, 8000));
    for (int i = 0; i < 8; i++) preload(i, $urandom);
    start_chk(14'd8);
    host_req = 1'b1; host_we = 4'h0; host_addr = haddr;
    for (int n = 0; n < 64 && nchk < 8; n++) begin
      #1;
      if (host_rvalid) begin
        vectors++;
        if (host_rdata !== ref_mem[haddr]) begin
          miscompares++; $display("FAIL cont_rdata: got %h expected %h", host_rdata, ref_mem[haddr]);
        end
      end
      if (!first) begin
        vectors++;
        if ({bram_en, host_gnt} !== {1'b1, ~prev}) begin
          miscompares++; $display("FAIL cont_alternate: en,gnt=%b expected 1%b", {bram_en, host_gnt}, ~prev);
        end
      end
      if (bram_en && !host_gnt) begin
        vectors++;
        if (bram_addr !== ADDR_W'(nchk)) begin
          miscompares++; $display("FAIL cont_chk_addr: got %h expected %h", bram_addr, nchk);
        end
        nchk++;
      end
      prev = host_gnt; first = 0;
      @(negedge core_clk);
    end
    host_req = 1'b0;
    wait_done(20, cyc, s);
    vectors++;
    if (nchk !== 8 || cyc < 0 || s !== ref_sum(8)) begin
      miscompares++; $display("FAIL cont_sum: reads=%0d sum=%h (cyc %0d) expected 8 %h", nchk, s, cyc, ref_sum(8));
    end
    $display("test_contention: len=8 reads=%0d sum=%h", nchk, s);
  endtask

  task automatic test_len_full();
    logic [ADDR_W:0] lens [2] = '{14'h2000, 14'h3FFF};
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    for (int k = 0; k < 2; k++) begin
      int nreads = 0, first_bad = -1, done_seen = 0;
      int exp_reads = (int'(lens[k]) > DEPTH) ? DEPTH : int'(lens[k]);
      logic [31:0] s = 0;
      start_chk(lens[k]);
      for (int n = 0; n < DEPTH + 64; n++) begin
        #1;
        if (bram_en) begin
          if (first_bad < 0 && bram_addr !== ADDR_W'(nreads)) first_bad = nreads;
          nreads++;
        end
        if (chk_done) begin done_seen = 1; s = chk_sum; break; end
        @(negedge core_clk);
      end
      vectors++;
      if (done_seen == 0 || nreads != exp_reads || first_bad >= 0 || s !== ref_sum(exp_reads)) begin
        miscompares++;
        $display("FAIL len_full_%h: done=%0d reads=%0d bad_at=%0d sum=%h expected 1 %0d -1 %h",
                 lens[k], done_seen, nreads, first_bad, s, exp_reads, ref_sum(exp_reads));
      end
      $display("test_len_full: len=%h reads=%0d sum=%h", lens[k], nreads, s);
    end
  endtask

  task automatic test_reset_mid_run();
    int got = -1, cyc, bad = 0; logic [31:0] s;
    start_chk(14'd16);
    host_req = 1'b1; host_we = 4'h0; host_addr = 13'h123;
    for (int n = 0; n < 8; n++) begin
      #1;
      if (host_gnt) begin got = n; break; end
      @(negedge core_clk);
    end
    vectors++;
    if (got < 0 || chk_busy !== 1'b1) begin
      miscompares++; $display("FAIL rst_run_setup: gnt_wait=%0d busy=%b expected >=0 1", got, chk_busy);
    end
    @(negedge core_clk);
    host_req = 1'b0;
    cptra_rst_b = 1'b0;
    #1;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL rst_run_outputs: got %h expected 0", all_outs());
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge core_clk); #1;
      if (chk_done || host_rvalid || chk_busy) bad++;
    end
    cptra_rst_b = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge core_clk); #1;
      if (chk_done || host_rvalid || chk_busy || chk_sum != 0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL rst_run_quiet: %0d active cycles expected 0", bad);
    end
    start_chk(14'd16);
    wait_done(60, cyc, s);
    vectors++;
    if (cyc < 0 || s !== ref_sum(16)) begin
      miscompares++; $display("FAIL rst_run_restart: got %h (cyc %0d) expected %h", s, cyc, ref_sum(16));
    end
    $display("test_reset_mid_run: restart sum=%h", s);
  endtask

  task automatic test_random();
    int w, cyc; logic e, en, r1, r2; logic [3:0] wq, we; logic [31:0] rd, d, s;
    logic lock; logic [ADDR_W-1:0] a;
    for (int t = 0; t < 150; t++) begin
      lock = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      a = ADDR_W'($urandom_range(0, 63));
      d = $urandom;
      rom_lock = lock;
      host_op(we, a, d, w, e, en, wq, r1, r2, rd);
      if (we != 0) begin
        if (!lock) ref_write(we, int'(a), d);
        vectors++;
        if (w !== 0 || e !== lock || en !== !lock || wq !== (lock ? 4'h0 : we)) begin
          miscompares++; $display("FAIL rnd_write: wait=%0d err=%b en=%b we=%h expected 0 %b %b %h",
                                  w, e, en, wq, lock, !lock, lock ? 4'h0 : we);
        end
        $display("rnd %0d: write a=%h we=%h d=%h lock=%b err=%b", t, a, we, d, lock, e);
      end else begin
        vectors++;
        if (r2 !== 1'b1 || rd !== ref_mem[a]) begin
          miscompares++; $display("FAIL rnd_read: rv=%b data=%h expected 1 %h", r2, rd, ref_mem[a]);
        end
        $display("rnd %0d: read a=%h data=%h", t, a, rd);
      end
    end
    rom_lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int len = $urandom_range(1, 64);
      start_chk(ADDR_W'(len));
      wait_done(100, cyc, s);
      vectors++;
      if (cyc < 0 || s !== ref_sum(len)) begin
        miscompares++; $display("FAIL rnd_chk: len=%0d got %h (cyc %0d) expected %h", len, s, cyc, ref_sum(len));
      end
      $display("rnd chk: len=%0d sum=%h", len, s);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      bram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    test_reset();
    test_write_read();
    test_checksum_basic();
    test_rom_lock();
    test_len_zero();
    test_contention();
    test_len_full();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, BRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, BRAM port-B data width.
REQ-003 SHALL have port core_clk input 1: sole clock; all ports synchronous to it.
REQ-004 SHALL have port cptra_rst_b input 1: asynchronous, active-low reset.
REQ-005 SHALL have ports host_req/host_we[3:0]/host_addr[ADDR_W]/host_wdata[DATA_W] as inputs: host access request, byte write enables (0 = read), word address and write data.
REQ-006 SHALL have ports host_gnt output 1, host_rvalid output 1, host_rdata output DATA_W and host_err output 1: access accepted, read data valid, read data and write-rejected pulse.
REQ-007 SHALL have ports rom_lock input 1, chk_start input 1 and chk_len input ADDR_W+1: block host writes, start checksum, and word count (0 allowed).
REQ-008 SHALL have ports chk_busy, chk_done and chk_sum[32] as outputs: checksum in progress, one-cycle completion pulse, and result.
REQ-009 SHALL have ports bram_en, bram_we[3:0], bram_addr[ADDR_W] and bram_wdata[DATA_W] as outputs, and bram_rdata[DATA_W] as input, forming the imem BRAM port B.

Function
REQ-010 SHALL share port B between the host and the internal checksum reader, issuing at most one access per cycle.
REQ-011 SHALL grant combinationally when only one requester is pending; when both are pending, it SHALL alternate, granting the requester not served on the last contended cycle (host first after reset).
REQ-012 SHALL assert host_gnt in the cycle its access drives bram_en; the host SHALL hold its request until granted.
REQ-013 SHALL sample bram_rdata one cycle after a read's bram_en, present it on host_rdata with a one-cycle host_rvalid pulse (2-cycle request-to-data latency), and hold host_rdata until the next read.
REQ-014 SHALL, while rom_lock=1, grant a host write with host_we!=0 but drive bram_en=0 and pulse host_err in the grant cycle; host reads stay permitted.
REQ-015 SHALL implement checker FSM IDLE->RUN on chk_start (when chk_len>0), RUN->DRAIN after issuing read chk_len-1, DRAIN->DONE when the final data is accumulated, and DONE->IDLE after one cycle; chk_start with chk_len=0 SHALL go to DONE directly with chk_sum=0.
REQ-016 SHALL in RUN issue reads at addresses 0..chk_len-1 incrementally, stalling the address counter on cycles the host wins arbitration.
REQ-017 SHALL clear chk_sum on chk_start and add each returned word modulo 2^32 (zero-extended when DATA_W<32, low 32 bits when DATA_W>32).
REQ-018 SHALL ignore chk_start while chk_busy=1 (RUN or DRAIN); chk_done SHALL be high only in DONE; chk_sum SHALL hold until the next accepted chk_start.
REQ-019 SHALL clamp chk_len to 2^ADDR_W so the address counter never wraps.
REQ-020 SHALL deassert bram_we when bram_en=0, and bram_we SHALL be nonzero only for granted, unlocked host writes.

Reset
REQ-021 SHALL, while cptra_rst_b=0, drive all outputs to 0, set FSM to IDLE and set round-robin pointer to host.
REQ-022 SHALL, on reset asserted mid-checksum, abandon the operation without a chk_done pulse, without a pending host_rvalid and with chk_sum=0.

Structure
REQ-023 SHALL take the checker state enum (IDLE, RUN, DRAIN, DONE) and the contention-pointer encoding from shared package fpga_imem_pkg.
REQ-024 SHALL place the FSM, address counter and accumulator in sub-module imem_chk_engine, with arbitration and BRAM muxing kept in the top level.

Verification
REQ-025 SHALL verify that a host write with we=4'hF, addr 0x010 and data 0xDEADBEEF, followed by a read of 0x010, returns host_rvalid two cycles after the read request with rdata 0xDEADBEEF.
REQ-026 SHALL verify that, after words 0..3 = 1,2,3,0xFFFFFFFF are preloaded, chk_len=4 with a chk_start pulse produces chk_done and chk_sum=0x00000005.
REQ-027 SHALL verify that, with rom_lock=1, a host write to 0x020 pulses host_err with bram_en=0, and a subsequent read returns the old value.
REQ-028 SHALL verify that, with host_req held continuously during a chk_len=8 run, grants strictly alternate, all 8 checker reads complete and the sum is correct.
REQ-029 SHALL verify that chk_len=0 gives chk_done one cycle after chk_start with chk_sum=0, and that chk_len=0x2000 reads addresses 0..0x1FFF with no wrap.
REQ-030 SHALL verify that cptra_rst_b asserted during RUN gives all outputs 0, no chk_done, and a clean result on a subsequent chk_start.
